// File: rtl/heat_grid_solver_pkg.sv
// heat_grid_solver_pkg: shared types for the heat-diffusion solver.
//   op_e    : 3-bit command opcodes carried on cmd_op
//   state_e : solver control states
//   bound_e : boundary handling mode for out-of-grid neighbours
//   ALPHA_SHIFT : fixed-point scale of alpha (alpha/8 per step)
package heat_grid_solver_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_WRITE     = 3'd1,
    OP_READ      = 3'd2,
    OP_CFG_ALPHA = 3'd3,
    OP_CFG_BOUND = 3'd4,
    OP_RUN       = 3'd5,
    OP_STOP      = 3'd6,
    OP_CLEAR     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  typedef enum logic {
    BND_FIXED = 1'b0,
    BND_INSUL = 1'b1
  } bound_e;

  localparam int ALPHA_SHIFT = 3;

endpackage

// File: rtl/heat_grid_solver_cell_update.sv
// heat_grid_solver_cell_update: combinational 5-point stencil for one cell.
//   c_i            : centre temperature
//   n_i/s_i/e_i/w_i: neighbour temperatures (boundary already substituted)
//   alpha_i        : diffusion coefficient in eighths
//   result_o       : clamp(c + floor((n+s+e+w-4c)*alpha / 8), 0, max)
module heat_grid_solver_cell_update
  import heat_grid_solver_pkg::*;
#(
  parameter int TEMP_W = 4
) (
  input  logic [TEMP_W-1:0] c_i,
  input  logic [TEMP_W-1:0] n_i,
  input  logic [TEMP_W-1:0] s_i,
  input  logic [TEMP_W-1:0] e_i,
  input  logic [TEMP_W-1:0] w_i,
  input  logic [2:0]        alpha_i,
  output logic [TEMP_W-1:0] result_o
);

  // Laplacian needs TEMP_W+2 magnitude bits plus sign; the product with a
  // 3-bit alpha needs three more, so PW leaves headroom for c+q as well.
  localparam int DW = TEMP_W + 4;
  localparam int PW = TEMP_W + 8;
  localparam logic signed [PW-1:0] TMAX = PW'((1 << TEMP_W) - 1);

  logic signed [DW-1:0] sum_s, delta_s;
  logic signed [PW-1:0] d_x, a_x, p_x, q_x, r_x;

  always_comb begin
    sum_s    = $signed({4'b0, n_i}) + $signed({4'b0, s_i})
             + $signed({4'b0, e_i}) + $signed({4'b0, w_i});
    delta_s  = sum_s - $signed({2'b00, c_i, 2'b00});
    d_x      = PW'(delta_s);
    a_x      = PW'($signed({1'b0, alpha_i}));
    p_x      = d_x * a_x;
    q_x      = p_x >>> ALPHA_SHIFT;  // arithmetic shift = floor division
    r_x      = q_x + $signed({8'b0, c_i});
    if (r_x[PW-1])       result_o = '0;
    else if (r_x > TMAX) result_o = '1;
    else                 result_o = r_x[TEMP_W-1:0];
  end

endmodule

// File: rtl/heat_grid_solver.sv
// heat_grid_solver: ROWS x COLS explicit heat-diffusion engine, one cell/clk.
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_valid/ready/op/addr/data : command port (opcodes in the package)
//   rd_valid, rd_data     : one-cycle read response
//   busy                  : sweeping or filling
//   done                  : one-cycle pulse when a RUN completes
//   iter_cnt              : completed iterations of the current/last RUN
// cur_q holds the last completed iteration; nxt_q collects the sweep in
// progress and is committed into cur_q on the final cell of each pass.
module heat_grid_solver
  import heat_grid_solver_pkg::*;
#(
  parameter  int ROWS   = 5,
  parameter  int COLS   = 5,
  parameter  int TEMP_W = 4,
  parameter  int ITER_W = 8,
  localparam int CELLS  = ROWS * COLS,
  localparam int ADDR_W = $clog2(CELLS),
  localparam int DATA_W = (TEMP_W > ITER_W) ? ((TEMP_W > 4) ? TEMP_W : 4)
                                            : ((ITER_W > 4) ? ITER_W : 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rd_valid,
  output logic [TEMP_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_V = (ADDR_W+1)'(CELLS);
  localparam logic [RW-1:0]     R_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]     C_LAST  = CW'(COLS - 1);

  state_e                        state_q, state_d;
  logic [CELLS-1:0][TEMP_W-1:0]  cur_q, nxt_q;
  logic [ADDR_W-1:0]             k_q;
  logic [RW-1:0]                 row_q;
  logic [CW-1:0]                 col_q;
  logic [2:0]                    alpha_q;
  bound_e                        mode_q;
  logic [TEMP_W-1:0]             bnd_q, fill_q;
  logic [ITER_W-1:0]             target_q, iter_q, iter_inc;
  logic                          rd_valid_q, done_q;
  logic [TEMP_W-1:0]             rd_data_q;

  logic accept, stop, addr_ok, k_last, last_iter;
  logic [TEMP_W-1:0] c_t, n_t, s_t, e_t, w_t, bnd_t, upd_t;

  assign cmd_ready = (state_q == ST_IDLE) | (cmd_op == OP_STOP);
  assign accept    = cmd_valid & cmd_ready;
  assign stop      = accept & (cmd_op == OP_STOP);
  assign addr_ok   = {1'b0, cmd_addr} < CELLS_V;
  assign k_last    = (k_q == K_LAST);
  assign iter_inc  = iter_q + ITER_W'(1);
  assign last_iter = k_last & (iter_inc == target_q);

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign iter_cnt = iter_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Neighbour muxes: row/col counters track k so no divider is needed.
  // Out-of-range indices are only ever formed on edge rows/cols, where the
  // boundary value is selected instead.
  always_comb begin
    c_t   = cur_q[k_q];
    bnd_t = (mode_q == BND_INSUL) ? c_t : bnd_q;
    n_t   = (row_q == '0)    ? bnd_t : cur_q[k_q - ADDR_W'(COLS)];
    s_t   = (row_q == R_LAST) ? bnd_t : cur_q[k_q + ADDR_W'(COLS)];
    w_t   = (col_q == '0)    ? bnd_t : cur_q[k_q - ADDR_W'(1)];
    e_t   = (col_q == C_LAST) ? bnd_t : cur_q[k_q + ADDR_W'(1)];
  end

  heat_grid_solver_cell_update #(.TEMP_W(TEMP_W)) u_upd (
    .c_i     (c_t),
    .n_i     (n_t),
    .s_i     (s_t),
    .e_i     (e_t),
    .w_i     (w_t),
    .alpha_i (alpha_q),
    .result_o(upd_t)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && cmd_op == OP_RUN && cmd_data[ITER_W-1:0] != '0)
          state_d = ST_SWEEP;
        else if (accept && cmd_op == OP_CLEAR)
          state_d = ST_FILL;
      end
      ST_SWEEP: if (stop || last_iter) state_d = ST_IDLE;
      ST_FILL:  if (stop || k_last)    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      alpha_q    <= '0;
      mode_q     <= BND_FIXED;
      bnd_q      <= '0;
      fill_q     <= '0;
      target_q   <= '0;
      iter_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      if (state_q == ST_IDLE && accept) begin
        case (op_e'(cmd_op))
          OP_WRITE: if (addr_ok) cur_q[cmd_addr] <= cmd_data[TEMP_W-1:0];
          OP_READ: begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= addr_ok ? cur_q[cmd_addr] : '0;
          end
          OP_CFG_ALPHA: alpha_q <= cmd_data[2:0];
          OP_CFG_BOUND: begin
            mode_q <= bound_e'(cmd_data[DATA_W-1]);
            bnd_q  <= cmd_data[TEMP_W-1:0];
          end
          OP_RUN: begin
            target_q <= cmd_data[ITER_W-1:0];
            iter_q   <= '0;
            k_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            if (cmd_data[ITER_W-1:0] == '0) done_q <= 1'b1;
          end
          OP_CLEAR: begin
            fill_q <= cmd_data[TEMP_W-1:0];
            k_q    <= '0;
            row_q  <= '0;
            col_q  <= '0;
          end
          default: ;
        endcase
      end else if (state_q == ST_SWEEP && !stop) begin
        nxt_q[k_q] <= upd_t;
        if (k_last) begin
          // Commit the pass; the last cell bypasses nxt_q.
          cur_q         <= nxt_q;
          cur_q[K_LAST] <= upd_t;
          iter_q        <= iter_inc;
          k_q           <= '0;
          row_q         <= '0;
          col_q         <= '0;
          if (last_iter) done_q <= 1'b1;
        end else begin
          k_q <= k_q + ADDR_W'(1);
          if (col_q == C_LAST) begin
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
      end else if (state_q == ST_FILL && !stop) begin
        cur_q[k_q] <= fill_q;
        k_q        <= k_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_heat_grid_solver.sv
// tb_heat_grid_solver: directed + randomized bench for heat_grid_solver with
// a 2-D integer reference model of the diffusion step.
module tb_heat_grid_solver;
  import heat_grid_solver_pkg::*;

  localparam int ROWS = 5, COLS = 5, TEMP_W = 4, ITER_W = 8;
  localparam int CELLS = ROWS * COLS, ADDR_W = 5, DATA_W = 8;

  logic              clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rd_valid, busy, done;
  logic [TEMP_W-1:0] rd_data;
  logic [ITER_W-1:0] iter_cnt;

  heat_grid_solver #(.ROWS(ROWS), .COLS(COLS), .TEMP_W(TEMP_W), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int g[ROWS][COLS];
  int m_alpha = 0, m_mode = 0, m_bound = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int floor8(input int p);
    return (p >= 0) ? p / 8 : -((-p + 7) / 8);
  endfunction

  function automatic int nb(input int r, input int c, input int cv);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return m_mode ? cv : m_bound;
    return g[r][c];
  endfunction

  task automatic model_step();
    int nx[ROWS][COLS];
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int cv, d, v;
        cv = g[r][c];
        d  = nb(r-1, c, cv) + nb(r+1, c, cv) + nb(r, c-1, cv) + nb(r, c+1, cv) - 4*cv;
        v  = cv + floor8(d * m_alpha);
        nx[r][c] = (v < 0) ? 0 : (v > 15) ? 15 : v;
      end
    g = nx;
  endtask

  task automatic model_fill(input int v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) g[r][c] = v;
  endtask

  // ---- stimulus helpers ----
  task automatic cmd(input op_e op, input int addr, input int data);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_addr = ADDR_W'(addr); cmd_data = DATA_W'(data);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic wr(input int addr, input int v);
    cmd(OP_WRITE, addr, v);
    if (addr < CELLS) g[addr / COLS][addr % COLS] = v;
  endtask

  task automatic cfg(input int alpha, input int mode, input int bound);
    cmd(OP_CFG_ALPHA, 0, alpha);
    cmd(OP_CFG_BOUND, 0, (mode << 7) | bound);
    m_alpha = alpha; m_mode = mode; m_bound = bound;
  endtask

  task automatic rd_chk(input string tag, input int addr, input int exp);
    cmd(OP_READ, addr, 0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 1);
    chk(tag, 32'(rd_data), exp);
  endtask

  task automatic check_grid(input string tag);
    for (int k = 0; k < CELLS; k++)
      rd_chk($sformatf("%s cell%0d", tag, k), k, g[k / COLS][k % COLS]);
  endtask

  task automatic clear(input int v);
    int e;
    cmd(OP_CLEAR, 0, v);
    chk("busy in FILL", 32'(busy), 1);
    e = 0;
    while (busy && e < CELLS + 10) begin @(negedge clk); e++; end
    chk("fill cycles", e, CELLS);
    chk("no done after fill", 32'(done), 0);
    model_fill(v);
  endtask

  task automatic run(input int n);
    int e;
    cmd(OP_RUN, 0, n);
    if (n > 0) chk("busy after RUN", 32'(busy), 1);
    e = 0;
    while (!done && e < n * CELLS + 20) begin @(negedge clk); e++; end
    chk($sformatf("RUN %0d done seen", n), 32'(done), 1);
    chk($sformatf("RUN %0d cycles", n), e, n * CELLS);
    chk("busy at done", 32'(busy), 0);
    chk("iter_cnt at done", 32'(iter_cnt), n);
    @(negedge clk);
    chk("done single pulse", 32'(done), 0);
    for (int i = 0; i < n; i++) model_step();
  endtask

  initial begin
    // reset
    model_fill(0);
    repeat (3) @(negedge clk);
    chk("rst rd_valid", 32'(rd_valid), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst iter_cnt", 32'(iter_cnt), 0);
    rst_n = 1'b1;
    rd_chk("rst cell7", 7, 0);
    chk("cmd_ready idle", 32'(cmd_ready), 1);

    // out-of-range address: write ignored, read returns 0
    wr(3, 11);
    wr(30, 5);
    rd_chk("oob read", 30, 0);
    rd_chk("cell3 write", 3, 11);
    wr(3, 0);

    // single hot centre, fixed boundary 0
    cfg(2, 0, 0);
    wr(12, 15);
    run(1);
    rd_chk("hot c12", 12, 0);
    rd_chk("hot c7", 7, 3);
    rd_chk("hot c13", 13, 3);
    rd_chk("hot c0", 0, 0);
    check_grid("hot");

    // cold grid, hot fixed boundary
    clear(0);
    cfg(2, 0, 15);
    run(1);
    rd_chk("bnd c0", 0, 7);
    rd_chk("bnd c1", 1, 3);
    rd_chk("bnd c6", 6, 0);
    check_grid("bnd");

    // insulated uniform grid is steady
    clear(9);
    cfg(2, 1, 3);
    run(5);
    rd_chk("ins c0", 0, 9);
    check_grid("ins");

    // clamp at the top
    cfg(7, 0, 15);
    clear(15);
    wr(12, 0);
    run(1);
    rd_chk("clamp c12", 12, 15);
    check_grid("clamp");

    // STOP mid-run: keeps first completed iteration
    for (int k = 0; k < CELLS; k++) wr(k, $urandom_range(0, 15));
    cfg(3, 0, 5);
    cmd(OP_RUN, 0, 3);
    for (int i = 0; i < 38; i++) begin
      @(negedge clk);
      if (done) chk("no done before STOP", 32'(done), 0);
    end
    cmd(OP_STOP, 0, 0);
    chk("stop busy", 32'(busy), 0);
    chk("stop done", 32'(done), 0);
    chk("stop iter_cnt", 32'(iter_cnt), 1);
    @(negedge clk);
    chk("stop no late done", 32'(done), 0);
    model_step();
    check_grid("stop");

    // RUN 0
    run(0);
    rd_chk("run0 c4", 4, g[0][4]);

    // randomized runs against the model
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < CELLS; k++) wr(k, $urandom_range(0, 15));
      cfg($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 15));
      run($urandom_range(1, 3));
      check_grid($sformatf("rand%0d", rnd));
    end

    // reset mid-run clears everything
    cmd(OP_RUN, 0, 3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_alpha = 0; m_mode = 0; m_bound = 0;
    model_fill(0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst iter_cnt", 32'(iter_cnt), 0);
    chk("midrst done", 32'(done), 0);
    check_grid("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
